// File: rtl/arm_multicycle_ctrl.sv
// arm_multicycle_ctrl: multicycle ARM control FSM with NZCV flag register and condition evaluation.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module arm_multicycle_ctrl #(
  parameter bit COND_FULL     = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [3:0]  ALUFlags,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUOp,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [3:0]  Flags,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXECR  = 4'd2,
    S_EXECI  = 4'd3,
    S_ALUWB  = 4'd4,
    S_MEMADR = 4'd5,
    S_MEMRD  = 4'd6,
    S_MEMWB  = 4'd7,
    S_MEMWR  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_CMP = 4'b1010;

  state_t      state_q, state_d;
  logic [3:0]  flags_q;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic        ready;
  logic        cond_ex;
  logic        req_int, mw_int, irw_int, pcw_int, rw_int;
  logic        unused_instr;

  assign cond  = instr[31:28];
  assign op    = instr[27:26];
  assign funct = instr[25:20];
  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign unused_instr = ^instr[19:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      if ((state_q == S_EXECR || state_q == S_EXECI) && funct[0])
        flags_q <= ALUFlags;
    end
  end

  // Condition evaluated from the registered flags, i.e. before this instruction executes.
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
    if (!COND_FULL && !(cond == 4'b0000 || cond == 4'b0001 || cond == 4'b1110))
      cond_ex = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    req_int   = 1'b0;
    mw_int    = 1'b0;
    irw_int   = 1'b0;
    pcw_int   = 1'b0;
    rw_int    = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 4'b0000;
    ImmSrc    = 2'b00;
    RegSrc    = 2'b00;
    case (state_q)
      S_FETCH: begin
        req_int   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ALUOp     = ALU_ADD;
        ResultSrc = 2'b10;
        irw_int   = ready;
        pcw_int   = ready;
        if (ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = ALU_ADD;
        RegSrc  = {(op == 2'b01) & ~funct[0], op == 2'b10};
        if (!cond_ex) state_d = S_FETCH;
        else begin
          case (op)
            2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
            2'b01:   state_d = S_MEMADR;
            2'b10:   state_d = S_BRANCH;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        ALUOp   = funct[4:1];
        state_d = (funct[4:1] == ALU_CMP) ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        rw_int  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMADR: begin
        ALUSrcB = funct[5] ? 2'b00 : 2'b01;
        ImmSrc  = 2'b01;
        ALUOp   = funct[3] ? ALU_ADD : ALU_SUB;
        RegSrc  = {~funct[0], 1'b0};
        state_d = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        req_int = 1'b1;
        AdrSrc  = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rw_int    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        req_int = 1'b1;
        AdrSrc  = 1'b1;
        mw_int  = 1'b1;
        RegSrc  = 2'b10;
        if (ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        RegSrc    = 2'b01;
        ALUSrcB   = 2'b01;
        ImmSrc    = 2'b10;
        ALUOp     = ALU_ADD;
        ResultSrc = 2'b10;
        pcw_int   = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are gated combinationally so an asserted reset blocks writes in the same cycle.
  assign mem_req  = req_int & ~reset;
  assign MemWrite = mw_int  & ~reset;
  assign IRWrite  = irw_int & ~reset;
  assign PCWrite  = pcw_int & ~reset;
  assign RegWrite = rw_int  & ~reset;
  assign Flags    = flags_q;
  assign state    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_arm_multicycle_ctrl.sv
// tb_arm_multicycle_ctrl: directed scoreboard bench for arm_multicycle_ctrl (full and reduced condition sets).
`default_nettype none
`timescale 1ns/1ps

module tb_arm_multicycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, reset0, mem_ready, sel0;
  logic [31:0] instr;
  logic [3:0]  alu_flags;

  logic       a_req, a_mw, a_adr, a_irw, a_pcw, a_rw, a_srca;
  logic [1:0] a_rs, a_srcb, a_imm, a_regsrc;
  logic [3:0] a_op, a_flags, a_state;
  logic       b_req, b_mw, b_adr, b_irw, b_pcw, b_rw, b_srca;
  logic [1:0] b_rs, b_srcb, b_imm, b_regsrc;
  logic [3:0] b_op, b_flags, b_state;

  arm_multicycle_ctrl #(.COND_FULL(1'b1), .MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .reset(reset), .instr(instr), .ALUFlags(alu_flags), .mem_ready(mem_ready),
    .mem_req(a_req), .MemWrite(a_mw), .AdrSrc(a_adr), .IRWrite(a_irw), .PCWrite(a_pcw),
    .RegWrite(a_rw), .ResultSrc(a_rs), .ALUSrcA(a_srca), .ALUSrcB(a_srcb), .ALUOp(a_op),
    .ImmSrc(a_imm), .RegSrc(a_regsrc), .Flags(a_flags), .state(a_state));

  arm_multicycle_ctrl #(.COND_FULL(1'b0), .MEM_HANDSHAKE(1'b1)) dut0 (
    .clk(clk), .reset(reset0), .instr(instr), .ALUFlags(alu_flags), .mem_ready(mem_ready),
    .mem_req(b_req), .MemWrite(b_mw), .AdrSrc(b_adr), .IRWrite(b_irw), .PCWrite(b_pcw),
    .RegWrite(b_rw), .ResultSrc(b_rs), .ALUSrcA(b_srca), .ALUSrcB(b_srcb), .ALUOp(b_op),
    .ImmSrc(b_imm), .RegSrc(b_regsrc), .Flags(b_flags), .state(b_state));

  logic       req, mw, irw, pcw, rw;
  logic [1:0] rs;
  logic [3:0] aop, flg, st;
  assign req = sel0 ? b_req   : a_req;
  assign mw  = sel0 ? b_mw    : a_mw;
  assign irw = sel0 ? b_irw   : a_irw;
  assign pcw = sel0 ? b_pcw   : a_pcw;
  assign rw  = sel0 ? b_rw    : a_rw;
  assign rs  = sel0 ? b_rs    : a_rs;
  assign aop = sel0 ? b_op    : a_op;
  assign flg = sel0 ? b_flags : a_flags;
  assign st  = sel0 ? b_state : a_state;

  typedef struct {
    int          cycles;
    logic [63:0] trace;
    int          rw;
    int          pcw;
    int          mw;
    int          ir;
    logic [3:0]  madr_op;
    logic [1:0]  rs_rw;
    logic [3:0]  flags;
  } rec_t;

  rec_t sb[$];
  int total = 0;
  int bad   = 0;

  localparam logic [31:0] ADDS_I = 32'hE2921005;
  localparam logic [31:0] CMP_R  = 32'hE1500000;
  localparam logic [31:0] BEQ    = 32'h0A000002;
  localparam logic [31:0] BNE    = 32'h1A000002;
  localparam logic [31:0] LDR    = 32'hE5921004;
  localparam logic [31:0] STR    = 32'hE5021008;
  localparam logic [31:0] ADD_R  = 32'hE0821003;
  localparam logic [31:0] ILLEG  = 32'hEC000000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t mk(input int cyc, input logic [63:0] tr, input int r, input int p,
                              input int m, input logic [3:0] mop, input logic [1:0] rsx,
                              input logic [3:0] f);
    rec_t e;
    e.cycles = cyc; e.trace = tr; e.rw = r; e.pcw = p; e.mw = m; e.ir = 1;
    e.madr_op = mop; e.rs_rw = rsx; e.flags = f;
    return e;
  endfunction

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f, input bit full);
    bit n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  r = z;
      4'd1:  r = !z;
      4'd2:  r = cy;
      4'd3:  r = !cy;
      4'd4:  r = n;
      4'd5:  r = !n;
      4'd6:  r = v;
      4'd7:  r = !v;
      4'd8:  r = cy && !z;
      4'd9:  r = !cy || z;
      4'd10: r = (n == v);
      4'd11: r = (n != v);
      4'd12: r = !z && (n == v);
      4'd13: r = z || (n != v);
      4'd14: r = 1'b1;
      default: r = 1'b0;
    endcase
    if (!full && !(c == 4'd0 || c == 4'd1 || c == 4'd14)) r = 1'b0;
    return r;
  endfunction

  // Runs one instruction from FETCH back to FETCH; called at a negedge with the DUT parked in FETCH.
  task automatic run(input string nm, input logic [31:0] ins, input logic [3:0] af,
                     input int fw, input int mwt, input rec_t e);
    rec_t o, x;
    int fwait, mwait, guard;
    bit left;
    fwait = fw; mwait = mwt; guard = 0; left = 1'b0;
    o = mk(0, 64'h0, 0, 0, 0, 4'h0, 2'b00, 4'h0);
    o.ir = 0;
    sb.push_back(e);
    instr = ins;
    alu_flags = af;
    while (1) begin
      if (st == 4'd0 && fwait > 0) begin mem_ready = 1'b0; fwait--; end
      else if ((st == 4'd6 || st == 4'd8) && mwait > 0) begin mem_ready = 1'b0; mwait--; end
      else mem_ready = 1'b1;
      #1;
      o.cycles++;
      o.trace = {o.trace[59:0], st};
      if (rw) begin o.rw++; o.rs_rw = rs; end
      if (pcw && st != 4'd0) o.pcw++;
      if (mw) o.mw++;
      if (irw) o.ir++;
      if (st == 4'd5) o.madr_op = aop;
      if (st != 4'd0) left = 1'b1;
      @(negedge clk);
      guard++;
      if (left && st == 4'd0) break;
      if (guard > 40) begin
        chk({nm, ".timeout"}, st, 64'd0);
        break;
      end
    end
    mem_ready = 1'b0;
    o.flags = flg;
    x = sb.pop_front();
    chk({nm, ".cycles"}, o.cycles, x.cycles);
    chk({nm, ".trace"},  o.trace,  x.trace);
    chk({nm, ".regwr"},  o.rw,     x.rw);
    chk({nm, ".pcwr"},   o.pcw,    x.pcw);
    chk({nm, ".memwr"},  o.mw,     x.mw);
    chk({nm, ".irwr"},   o.ir,     x.ir);
    chk({nm, ".madrop"}, o.madr_op, x.madr_op);
    chk({nm, ".rsrc"},   o.rs_rw,  x.rs_rw);
    chk({nm, ".flags"},  o.flags,  x.flags);
  endtask

  task automatic sweep(input bit full);
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        logic [3:0] cc, ff;
        logic [31:0] ti;
        cc = c[3:0]; ff = f[3:0];
        ti = {cc, 28'h2821005};
        run($sformatf("pre%0d_%0d_%0d", full, c, f), ADDS_I, ff, 0, 0,
            mk(4, 64'h0134, 1, 0, 0, 4'h0, 2'b00, ff));
        if (cond_ok(cc, ff, full))
          run($sformatf("sw%0d_%0d_%0d", full, c, f), ti, ~ff, 0, 0,
              mk(4, 64'h0134, 1, 0, 0, 4'h0, 2'b00, ff));
        else
          run($sformatf("sw%0d_%0d_%0d", full, c, f), ti, ~ff, 0, 0,
              mk(2, 64'h01, 0, 0, 0, 4'h0, 2'b00, ff));
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; reset0 = 1'b1; sel0 = 1'b0;
    mem_ready = 1'b1; instr = ADDS_I; alu_flags = 4'h0;
    @(posedge clk);
    @(negedge clk); #1;
    chk("rst.state",  st,  64'd0);
    chk("rst.flags",  flg, 64'd0);
    chk("rst.memreq", req, 64'd0);
    chk("rst.irwr",   irw, 64'd0);
    chk("rst.pcwr",   pcw, 64'd0);
    mem_ready = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    run("adds",  ADDS_I, 4'b0100, 0, 0, mk(4, 64'h0134,    1, 0, 0, 4'h0, 2'b00, 4'b0100));
    run("cmp",   CMP_R,  4'b0100, 0, 0, mk(3, 64'h012,     0, 0, 0, 4'h0, 2'b00, 4'b0100));
    run("beq",   BEQ,    4'b0000, 0, 0, mk(3, 64'h019,     0, 1, 0, 4'h0, 2'b00, 4'b0100));
    run("bne",   BNE,    4'b0000, 0, 0, mk(2, 64'h01,      0, 0, 0, 4'h0, 2'b00, 4'b0100));
    run("ldr",   LDR,    4'b0000, 0, 2, mk(7, 64'h0156667, 1, 0, 0, 4'h4, 2'b01, 4'b0100));
    run("str",   STR,    4'b0000, 0, 0, mk(4, 64'h0158,    0, 0, 1, 4'h2, 2'b00, 4'b0100));
    run("strw",  STR,    4'b0000, 0, 1, mk(5, 64'h01588,   0, 0, 2, 4'h2, 2'b00, 4'b0100));
    run("addfw", ADD_R,  4'b1111, 2, 0, mk(6, 64'h000124,  1, 0, 0, 4'h0, 2'b00, 4'b0100));
    run("illeg", ILLEG,  4'b1111, 0, 0, mk(2, 64'h01,      0, 0, 0, 4'h0, 2'b00, 4'b0100));
    run("setf",  ADDS_I, 4'b1010, 0, 0, mk(4, 64'h0134,    1, 0, 0, 4'h0, 2'b00, 4'b1010));

    // Abandon a store stalled in MEMWR.
    instr = STR;
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (st == 4'd8) break;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    #1;
    chk("mwr.state", st, 64'd8);
    chk("mwr.memwr", mw, 64'd1);
    @(negedge clk); #1;
    chk("mwr.hold",  mw, 64'd1);
    reset = 1'b1;
    #1;
    chk("mwr.rst_memwr",  mw,  64'd0);
    chk("mwr.rst_memreq", req, 64'd0);
    @(negedge clk); #1;
    chk("mwr.rst_state", st,  64'd0);
    chk("mwr.rst_flags", flg, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    run("after", ADDS_I, 4'b0001, 0, 0, mk(4, 64'h0134, 1, 0, 0, 4'h0, 2'b00, 4'b0001));

    sweep(1'b1);

    reset = 1'b1;
    sel0 = 1'b1;
    @(negedge clk);
    reset0 = 1'b0;
    @(negedge clk);
    sweep(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
